store_buffer: RTL
=================

# store_buffer

Store-side counterpart to the write-back load path. It accepts committed store operations (SB, SH, SW) and converts each into a word-aligned memory write with byte enables and lane-replicated data. Pending writes sit in a small FIFO and drain to data memory over a request/grant handshake. The block also reports misaligned stores and flags loads that hit a word still waiting in the buffer.

## Interface
Parameters:
- DEPTH, 2: number of buffered stores; power of two, ≥2.

Ports:
- clk  in  1  core clock; everything is sampled on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- store_valid_i  in  1  store request present this cycle.
- store_ready_o  out  1  buffer can accept a store; equals !full.
- instruction_operation_i  in  iType_e  operation; only SB, SH, SW are acted on.
- address_i  in  32  byte address of the store.
- data_i  in  32  register data to store (lsb-justified).
- misaligned_o  out  1  one-cycle registered pulse: the previous-cycle store was rejected.
- mem_req_o  out  1  write request to data memory.
- mem_gnt_i  in  1  memory accepts the current request.
- mem_address_o  out  32  head-entry word address; bits [1:0] are always 0.
- mem_write_enable_o  out  4  head-entry byte strobes, one bit per lane.
- mem_data_o  out  32  head-entry lane-replicated data.
- load_address_i  in  32  address of the load currently in execute.
- load_conflict_o  out  1  a buffered entry has the same word address as the load.
- empty_o  out  1  no pending stores.

## Operation
- **Accept** when store_valid_i && store_ready_o, the operation is SB, SH or SW, and the address is aligned.
  - The tail entry is written and the tail pointer advances modulo DEPTH.
  - Any other operation with store_valid_i is ignored: no enqueue, no misaligned pulse.
- **Alignment rules**
  - SH with address_i[0]=1 is misaligned.
  - SW with address_i[1:0]≠0 is misaligned.
  - SB is never misaligned.
  - A misaligned store is not enqueued; misaligned_o=1 in the following cycle.
  - The misaligned check happens only when store_ready_o=1. A store offered while full is neither accepted nor flagged.
- **Entry encoding** (a = address_i[1:0]):
  - SB: we = 4'b0001 << a; data = {4{data_i[7:0]}}.
  - SH: we = a[1] ? 4'b1100 : 4'b0011; data = {2{data_i[15:0]}}.
  - SW: we = 4'b1111; data = data_i.
  - Address stored as {address_i[31:2], 2'b00}.
- **Drain**
  - mem_req_o = !empty. The mem_* outputs show the head entry directly from registers.
  - On mem_req_o && mem_gnt_i the head pops and the head pointer advances modulo DEPTH.
  - While a request is waiting for grant, mem_address_o, mem_write_enable_o and mem_data_o stay stable.
- **Count**
  - Width $clog2(DEPTH)+1. Full when count==DEPTH, empty when count==0.
  - Simultaneous push and pop leaves count unchanged.
  - No push is possible while full, even in a pop cycle. store_ready_o is based only on registered state.
- **Conflict**
  - load_conflict_o is the combinational OR, over valid entries, of entry_address[31:2]==load_address_i[31:2].
  - A store being accepted in the same cycle is not included.
- **Reset (asynchronous)**
  - Clears pointers, count and all entry storage; pending stores are discarded.
  - Reset values: store_ready_o=1, empty_o=1, mem_req_o=0, mem_address_o=0, mem_write_enable_o=0, mem_data_o=0, misaligned_o=0, load_conflict_o=0.

## Timing
- Accept at edge N → mem_req_o=1 in cycle N+1 if the buffer was empty, with that entry's values.
- Minimum accept-to-memory latency is 1 cycle. With mem_gnt_i tied high, one store retires per cycle.
- Grant at edge M pops the head. The next entry, if any, is on mem_* in cycle M+1; otherwise mem_req_o=0.
- store_ready_o rises the cycle after a pop from full.
- misaligned_o is high for exactly one cycle, the cycle after the offending request.
- load_conflict_o has zero latency with respect to load_address_i and register state.

## Test plan
- **Reset and byte store:** after reset check every output value; then SB addr 0x1003, data 0xA5 → next cycle mem_req_o=1, addr 0x1000, we 4'b1000, data 0xA5A5A5A5.
- **Halfword and word stores:** SH addr 0x2002, data 0x1234BEEF → we 4'b1100, data 0xBEEFBEEF. SW addr 0x3000, data 0xDEADBEEF → we 4'b1111, data unchanged.
- **Misaligned stores:** SH 0x4001 and SW 0x4002 → misaligned_o pulses one cycle each, empty_o stays 1, no mem_req_o. A non-store operation with store_valid_i → no effect.
- **Fill and back-pressure (DEPTH=2):** mem_gnt_i=0, issue 3 stores → store_ready_o=0 after 2 and the 3rd is not accepted. Outputs stay stable while held. Raise mem_gnt_i → FIFO-order drain, store_ready_o=1 the cycle after the first pop, pointers wrap correctly.
- **Load conflict:** pending SB 0x5001; load_address_i 0x5003 → load_conflict_o=1; 0x5004 → 0. After the grant pops the entry → 0.
- **Reset mid-drain:** two entries pending, assert reset asynchronously between edges → outputs go to reset values immediately; no stale request after reset is released.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: turns committed SB/SH/SW stores into word-aligned, byte-strobed memory writes
// held in a small FIFO that drains over a req/gnt handshake; flags misaligned stores and load hits.
module store_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_valid_i,
  output logic        store_ready_o,
  input  logic [3:0]  instruction_operation_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_i,
  output logic        misaligned_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_address_o,
  output logic [3:0]  mem_write_enable_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] load_address_i,
  output logic        load_conflict_o,
  output logic        empty_o
);
  localparam logic [3:0] OP_SB = 4'h8;
  localparam logic [3:0] OP_SH = 4'h9;
  localparam logic [3:0] OP_SW = 4'hA;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [3:0]    we_q   [DEPTH];
  logic [AW-1:0] head, tail, off;
  logic [CW-1:0] count;
  logic          is_sb, is_sh, is_sw, mis, attempt, push, pop;
  logic [3:0]    we_in;
  logic [31:0]   data_in;

  assign store_ready_o      = count != CW'(DEPTH);
  assign empty_o            = count == '0;
  assign mem_req_o          = !empty_o;
  assign mem_address_o      = addr_q[head];
  assign mem_write_enable_o = we_q[head];
  assign mem_data_o         = data_q[head];

  always_comb begin
    is_sb   = instruction_operation_i == OP_SB;
    is_sh   = instruction_operation_i == OP_SH;
    is_sw   = instruction_operation_i == OP_SW;
    mis     = (is_sh & address_i[0]) | (is_sw & |address_i[1:0]);
    attempt = store_valid_i & store_ready_o & (is_sb | is_sh | is_sw);
    push    = attempt & !mis;
    pop     = mem_req_o & mem_gnt_i;
    we_in   = is_sw ? 4'b1111 : is_sh ? (address_i[1] ? 4'b1100 : 4'b0011) : 4'b0001 << address_i[1:0];
    data_in = is_sw ? data_i : is_sh ? {2{data_i[15:0]}} : {4{data_i[7:0]}};
  end

  // An entry is live when its distance from head is below count.
  always_comb begin
    load_conflict_o = 1'b0;
    off             = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - head;
      if ({1'b0, off} < count && addr_q[i][31:2] == load_address_i[31:2])
        load_conflict_o = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      misaligned_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        we_q[i]   <= '0;
      end
    end else begin
      misaligned_o <= attempt & mis;
      if (push) begin
        addr_q[tail] <= {address_i[31:2], 2'b00};
        data_q[tail] <= data_in;
        we_q[tail]   <= we_in;
        tail         <= tail + AW'(1);
      end
      if (pop)
        head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule
